snn_input_loader: RTL and testbench

Upstream feeder for the SNN core. It takes bytes from the UART receiver and unpacks each one into 8 single-bit writes to the 784x1 input-unit RAM. After 98 bytes (784 pixels) it pulses load_done to the top-level control FSM, which then starts the core. It buffers one byte while unpacking, flags overruns, and stays frozen until re-armed after the result has been transmitted.

---
 rtl/snn_pkg.sv | 14 +
 rtl/snn_input_loader.sv | 168 ++++++++++++++++
 tb/tb_snn_input_loader.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN input path.
package snn_pkg;

  localparam int NUM_INPUT_BYTES = 98;
  localparam int NUM_INPUTS      = NUM_INPUT_BYTES * 8;
  localparam int INPUT_ADDR_W    = 10;

  typedef enum logic [1:0] {
    ARMED = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } loader_state_t;

endpackage

// File: rtl/snn_input_loader.sv
// Unpacks UART bytes into single-bit writes to the input-unit RAM, LSB first.
// One byte can be held while another is being shifted out; a byte arriving
// while the hold slot is occupied is dropped and flagged via sticky overrun.
module snn_input_loader
  import snn_pkg::*;
#(
  parameter int NUM_BYTES = NUM_INPUT_BYTES,
  parameter int ADDR_W    = INPUT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic              rearm,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_d,
  output logic              load_done,
  output logic              loading,
  output logic              overrun
);

  localparam int CNT_W = $clog2(NUM_BYTES + 1);

  loader_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic              hold_valid_q, hold_valid_d;
  logic [7:0]        shift_q, hold_q;

  logic              we_d, d_d, done_d, loading_d, overrun_d;
  logic [ADDR_W-1:0] addr_d;
  logic              start_rx, start_hold, cap_hold;

  // Address of bit 0 of byte c.
  function automatic logic [ADDR_W-1:0] byte_base(input logic [CNT_W-1:0] c);
    return ADDR_W'({c, 3'b000});
  endfunction

  // Next-state and next-output decode; rearm overrides everything.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    hold_valid_d = hold_valid_q;
    we_d         = 1'b0;
    addr_d       = ram_addr;
    d_d          = ram_d;
    done_d       = 1'b0;
    loading_d    = loading;
    overrun_d    = overrun;
    start_rx     = 1'b0;
    start_hold   = 1'b0;
    cap_hold     = 1'b0;

    if (rearm) begin
      state_d      = ARMED;
      cnt_d        = '0;
      hold_valid_d = 1'b0;
      overrun_d    = 1'b0;
      loading_d    = 1'b0;
      if (rx_rdy) begin
        // Same-cycle byte becomes byte 0 of the new image.
        state_d   = SHIFT;
        start_rx  = 1'b1;
        loading_d = 1'b1;
        we_d      = 1'b1;
        addr_d    = '0;
        d_d       = rx_data[0];
        bit_d     = 3'd0;
      end
    end else begin
      unique case (state_q)
        ARMED: begin
          if (rx_rdy) begin
            state_d   = SHIFT;
            start_rx  = 1'b1;
            loading_d = 1'b1;
            we_d      = 1'b1;
            addr_d    = byte_base(cnt_q);
            d_d       = rx_data[0];
            bit_d     = 3'd0;
          end
        end
        SHIFT: begin
          if (bit_q != 3'd7) begin
            we_d   = 1'b1;
            addr_d = ram_addr + ADDR_W'(1);
            bit_d  = bit_q + 3'd1;
            d_d    = shift_q[bit_q + 3'd1];
            if (rx_rdy) begin
              if (hold_valid_q) begin
                overrun_d = 1'b1;
              end else begin
                cap_hold     = 1'b1;
                hold_valid_d = 1'b1;
              end
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_BYTES - 1)) begin
              // Image complete: anything held or arriving now is discarded.
              state_d      = FULL;
              done_d       = 1'b1;
              loading_d    = 1'b0;
              hold_valid_d = 1'b0;
            end else if (hold_valid_q) begin
              start_hold   = 1'b1;
              hold_valid_d = 1'b0;
              we_d         = 1'b1;
              addr_d       = ram_addr + ADDR_W'(1);
              d_d          = hold_q[0];
              bit_d        = 3'd0;
              if (rx_rdy) overrun_d = 1'b1;
            end else if (rx_rdy) begin
              // Byte arriving on the last bit goes straight into the shifter.
              start_rx = 1'b1;
              we_d     = 1'b1;
              addr_d   = ram_addr + ADDR_W'(1);
              d_d      = rx_data[0];
              bit_d    = 3'd0;
            end else begin
              state_d = ARMED;
            end
          end
        end
        FULL: begin
        end
        default: state_d = ARMED;
      endcase
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARMED;
      cnt_q        <= '0;
      bit_q        <= 3'd0;
      hold_valid_q <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_d        <= 1'b0;
      load_done    <= 1'b0;
      loading      <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      hold_valid_q <= hold_valid_d;
      ram_we       <= we_d;
      ram_addr     <= addr_d;
      ram_d        <= d_d;
      load_done    <= done_d;
      loading      <= loading_d;
      overrun      <= overrun_d;
    end
  end

  // Shift and hold byte storage; qualified by control, so no reset needed.
  always_ff @(posedge clk) begin
    if (start_rx)        shift_q <= rx_data;
    else if (start_hold) shift_q <= hold_q;
    if (cap_hold)        hold_q  <= rx_data;
  end

endmodule

// File: tb/tb_snn_input_loader.sv
// Scoreboard bench for snn_input_loader: expected RAM writes are queued as
// bytes are issued and popped by a monitor whenever ram_we is seen.
module tb_snn_input_loader;

  localparam int NB = 98;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          rearm;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic          ram_d;
  logic          load_done;
  logic          loading;
  logic          overrun;

  snn_input_loader #(.NUM_BYTES(NB), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .rearm     (rearm),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_d     (ram_d),
    .load_done (load_done),
    .loading   (loading),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          d;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  next_addr = 0;
  int  done_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Queue the eight expected pixel writes of an accepted byte.
  task automatic push_byte(input logic [7:0] b);
    wr_t w;
    for (int i = 0; i < 8; i++) begin
      w.addr = AW'(next_addr + i);
      w.d    = b[i];
      sb.push_back(w);
    end
    next_addr += 8;
  endtask

  // Present inputs for exactly one sampling edge.
  task automatic drive(input logic r, input logic [7:0] d, input logic ra);
    @(posedge clk);
    #1;
    rx_rdy  = r;
    rx_data = d;
    rearm   = ra;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_we"},      int'(ram_we),    0);
    check({tag, "_addr"},    int'(ram_addr),  0);
    check({tag, "_d"},       int'(ram_d),     0);
    check({tag, "_done"},    int'(load_done), 0);
    check({tag, "_loading"}, int'(loading),   0);
    check({tag, "_overrun"}, int'(overrun),   0);
  endtask

  initial begin
    logic [7:0] b;
    rst_n   = 1'b0;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
    rearm   = 1'b0;

    // Write monitor / scoreboard consumer.
    fork
      begin
        logic          prev_we = 1'b0;
        logic          prev_done = 1'b0;
        logic [AW-1:0] prev_addr = '0;
        wr_t           e;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (ram_we) begin
              checks++;
              if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d d=%0b, expected no write", ram_addr, ram_d);
              end else begin
                e = sb.pop_front();
                if (ram_addr !== e.addr || ram_d !== e.d) begin
                  errors++;
                  $display("FAIL write: got addr=%0d d=%0b, expected addr=%0d d=%0b",
                           ram_addr, ram_d, e.addr, e.d);
                end
              end
            end
            if (load_done) begin
              done_cnt++;
              checks++;
              if (!(prev_we && prev_addr == AW'(NB * 8 - 1) && !prev_done)) begin
                errors++;
                $display("FAIL load_done_timing: got prev_we=%0b prev_addr=%0d prev_done=%0b, expected 1/%0d/0",
                         prev_we, prev_addr, prev_done, NB * 8 - 1);
              end
            end
            prev_we   = ram_we;
            prev_addr = ram_addr;
            prev_done = load_done;
          end
        end
      end
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a byte
    idle(2);
    push_byte(8'h3C);
    drive(1'b1, 8'h3C, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    sb.delete();
    next_addr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_byte(8'h01);
    drive(1'b1, 8'h01, 1'b0);
    idle(12);
    check("after_reset_drained", sb.size(), 0);

    // Single byte 0xA5
    drive(1'b0, 8'h00, 1'b1);
    next_addr = 0;
    idle(2);
    push_byte(8'hA5);
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("single_loading", int'(loading), 1);
    check("single_we_first", int'(ram_we), 1);
    idle(12);
    check("single_drained", sb.size(), 0);

    // Back-to-back: second byte held and written without a gap
    drive(1'b0, 8'h00, 1'b1);
    next_addr = 0;
    idle(2);
    push_byte(8'hFF);
    push_byte(8'h00);
    drive(1'b1, 8'hFF, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    for (int i = 3; i <= 16; i++) begin
      @(negedge clk);
      check($sformatf("b2b_we_t%0d", i), int'(ram_we), 1);
    end
    @(negedge clk);
    check("b2b_we_end", int'(ram_we), 0);
    check("b2b_overrun", int'(overrun), 0);
    idle(4);
    check("b2b_drained", sb.size(), 0);

    // Overrun: third consecutive byte is dropped
    drive(1'b0, 8'h00, 1'b1);
    next_addr = 0;
    idle(2);
    push_byte(8'h11);
    push_byte(8'h22);
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    drive(1'b1, 8'h33, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    check("ovr_flag", int'(overrun), 1);
    idle(25);
    check("ovr_drained", sb.size(), 0);
    check("ovr_sticky", int'(overrun), 1);

    // Full image; starts with an overrun so the flag is sticky into FULL
    drive(1'b0, 8'h00, 1'b1);
    next_addr = 0;
    idle(2);
    done_cnt = 0;
    push_byte(8'd5);
    push_byte(8'd42);
    drive(1'b1, 8'd5, 1'b0);
    drive(1'b1, 8'd42, 1'b0);
    drive(1'b1, 8'hEE, 1'b0);
    idle(20);
    for (int k = 2; k < NB; k++) begin
      b = 8'((k * 37 + 5) & 255);
      push_byte(b);
      drive(1'b1, b, 1'b0);
      idle(19);
    end
    check("full_drained", sb.size(), 0);
    check("full_done_pulses", done_cnt, 1);
    check("full_loading", int'(loading), 0);
    check("full_overrun_kept", int'(overrun), 1);
    drive(1'b1, 8'h77, 1'b0);
    idle(15);
    check("full_ignore_done", done_cnt, 1);
    check("full_ignore_overrun", int'(overrun), 1);

    // Rearm from FULL, then 0x80 lands at address 0
    drive(1'b0, 8'h00, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    next_addr = 0;
    @(negedge clk);
    check("rearm_overrun", int'(overrun), 0);
    check("rearm_loading", int'(loading), 0);
    push_byte(8'h80);
    drive(1'b1, 8'h80, 1'b0);
    idle(12);
    check("rearm_drained", sb.size(), 0);

    // rearm and rx_rdy together: byte becomes byte 0
    next_addr = 0;
    push_byte(8'h5A);
    drive(1'b1, 8'h5A, 1'b1);
    idle(12);
    check("same_cycle_drained", sb.size(), 0);
    check("same_cycle_loading", int'(loading), 1);
    check("same_cycle_done", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
